// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  // Booth recoding of {Q[0], q_m1}
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned count_width(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit add/subtract built from 4-bit carry-lookahead slices.
module booth_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  localparam int unsigned NS = (W + 3) / 4;
  localparam int unsigned PW = NS * 4;

  logic [W-1:0]  w_b_eff;
  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;
  logic [PW-1:0] w_s;
  logic [NS:0]   w_c;
  logic          w_unused;

  // Subtraction is A + ~B + 1, the +1 entering as slice-0 carry-in
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_a     = PW'(i_a);
  assign w_b     = PW'(w_b_eff);
  assign w_c[0]  = i_sub;

  for (genvar s = 0; s < NS; s++) begin : g_cla
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_cc;

    assign w_g     = w_a[4*s +: 4] & w_b[4*s +: 4];
    assign w_p     = w_a[4*s +: 4] ^ w_b[4*s +: 4];
    assign w_cc[0] = w_c[s];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_c[s]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[s]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_c[s]);
    assign w_c[s+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                    | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[s]);
    assign w_s[4*s +: 4] = w_p ^ w_cc;
  end

  assign o_sum    = w_s[W-1:0];
  assign w_unused = ^{w_s, w_c[NS]};

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Optional MUL_SIGN_SEL_EN adds signed_op for unsigned/signed selection.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
`ifdef MUL_SIGN_SEL_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = WIDTH + 1;
`ifdef MUL_SIGN_SEL_EN
  localparam int unsigned QW   = WIDTH + 1;
  localparam int unsigned ITER = WIDTH + 1;
`else
  localparam int unsigned QW   = WIDTH;
  localparam int unsigned ITER = WIDTH;
`endif
  localparam int unsigned CW = count_width(ITER);

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_a, w_a_nxt;
  logic [AW-1:0]  r_m, w_m_nxt;
  logic [QW-1:0]  r_q, w_q_nxt;
  logic           r_qm1, w_qm1_nxt;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  logic [1:0]       w_sel;
  logic             w_sub;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_acc;
  logic [AW-1:0]    w_a_sh;
  logic [QW-1:0]    w_q_sh;
  logic [AW-1:0]    w_m_ld;
  logic [QW-1:0]    w_q_ld;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  assign w_sel = {r_q[0], r_qm1};
  assign w_sub = (w_sel == BOOTH_SUB);

  booth_addsub #(.W(AW)) u_addsub (
    .i_a   (r_a),
    .i_b   (r_m),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  assign w_acc  = ((w_sel == BOOTH_ADD) || (w_sel == BOOTH_SUB)) ? w_sum : r_a;
  assign w_a_sh = {w_acc[AW-1], w_acc[AW-1:1]};
  assign w_q_sh = {w_acc[0], r_q[QW-1:1]};

`ifdef MUL_SIGN_SEL_EN
  // Unsigned operands become non-negative (WIDTH+1)-bit signed values
  assign w_m_ld   = {signed_op & multiplicand[WIDTH-1], multiplicand};
  assign w_q_ld   = {signed_op & multiplier[WIDTH-1], multiplier};
  assign w_hi_res = {w_a_sh[WIDTH-2:0], w_q_sh[WIDTH]};
  assign w_lo_res = w_q_sh[WIDTH-1:0];
`else
  assign w_m_ld   = {multiplicand[WIDTH-1], multiplicand};
  assign w_q_ld   = multiplier;
  assign w_hi_res = w_a_sh[WIDTH-1:0];
  assign w_lo_res = w_q_sh;
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_m_nxt     = r_m;
    w_q_nxt     = r_q;
    w_qm1_nxt   = r_qm1;
    w_count_nxt = r_count;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nxt     = '0;
          w_m_nxt     = w_m_ld;
          w_q_nxt     = w_q_ld;
          w_qm1_nxt   = 1'b0;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_a_nxt     = w_a_sh;
        w_q_nxt     = w_q_sh;
        w_qm1_nxt   = r_q[0];
        w_count_nxt = r_count + CW'(1);
        if (r_count == CW'(ITER - 1)) begin
          w_hi_nxt    = w_hi_res;
          w_lo_nxt    = w_lo_res;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_m     <= w_m_nxt;
      r_q     <= w_q_nxt;
      r_qm1   <= w_qm1_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: products and done timing vs. a behavioural model.
module tb_booth_mul_seq;

  localparam int W = 32;
`ifdef MUL_SIGN_SEL_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic         sgn = 1'b1;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
`ifdef MUL_SIGN_SEL_EN
    .signed_op    (sgn),
`endif
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    exp_t e;
    int   n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    multiplicand = m;
    multiplier   = q;
    sgn          = s;
    start        = 1'b1;
`ifdef MUL_SIGN_SEL_EN
    e.prod = s ? 64'(longint'($signed(m)) * longint'($signed(q)))
               : 64'(longint'(m) * longint'(q));
`else
    e.prod = 64'(longint'($signed(m)) * longint'($signed(q)));
`endif
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(n < 500), 64'(1));
  endtask

  // Every done pulse must match the oldest outstanding operation
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("done_cyc", 64'(cyc), 64'(mon_e.cyc));
        check("hi", 64'(hi), 64'(mon_e.prod[2*W-1:W]));
        check("lo", 64'(lo), 64'(mon_e.prod[W-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int bc;
    int n;
    logic [W-1:0] rm, rq;

    repeat (3) step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    clr = 1'b0;
    step();

    // 6*7 with busy window measured
    do_mul(32'd6, 32'd7, 1'b1);
    bc = 0;
    for (int i = 0; i < LAT; i++) begin
      if (busy) bc++;
      step();
    end
    check("busy_cycles", 64'(bc), 64'(LAT));
    check("busy_end", 64'(busy), 64'(0));
    check("done_pulse", 64'(done), 64'(1));
    step();
    check("done_one_cycle", 64'(done), 64'(0));
    check("hold_lo", 64'(lo), 64'h2A);

    do_mul(32'hFFFF_FFFD, 32'd5, 1'b1);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
    do_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_idle();
    check("corner_hi", 64'(hi), 64'hC000_0000);
    check("corner_lo", 64'(lo), 64'h8000_0000);

    // start while busy is ignored, operands change mid-op
    do_mul(32'd6, 32'd7, 1'b1);
    repeat (9) step();
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    check("done_wait", 64'(n < 200), 64'(1));
    check("ignored_lo", 64'(lo), 64'h2A);
    do_mul(32'd9, 32'd9, 1'b1);
    wait_idle();
    check("back2back_lo", 64'(lo), 64'h51);

    for (int k = 0; k < 8; k++) begin
      rm = $urandom();
      rq = $urandom();
      if (k == 0) rm = 32'h8000_0000;
      if (k == 1) rq = 32'hFFFF_FFFF;
      do_mul(rm, rq, 1'b1);
    end
    wait_idle();

    // asynchronous clear mid-operation discards the result
    multiplicand = 32'd6;
    multiplier   = 32'd7;
    start        = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    #2;
    clr = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'(0));
    check("clr_done", 64'(done), 64'(0));
    check("clr_hi", 64'(hi), 64'(0));
    check("clr_lo", 64'(lo), 64'(0));
    @(posedge clk);
    #3;
    clr = 1'b0;
    repeat (LAT + 5) step();
    check("clr_no_result", 64'({hi, lo}), 64'(0));
    do_mul(32'd123, 32'hFFFF_FFB3, 1'b1);
    wait_idle();

`ifdef MUL_SIGN_SEL_EN
    do_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    check("uns_hi", 64'(hi), 64'h1);
    check("uns_lo", 64'(lo), 64'hFFFF_FFFE);
    do_mul(32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle();
    check("sgn_hi", 64'(hi), 64'hFFFF_FFFF);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b0);
    for (int k = 0; k < 4; k++) do_mul($urandom(), $urandom(), 1'($urandom_range(0, 1)));
    wait_idle();
`endif

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
